apx_mult_seq_engine: RTL and testbench

//  Sequential responder for operand-pair streams. Accepts one signed (a,b) pair per valid/ready

---
 rtl/apx_mult_seq_engine.sv | 108 ++++++++++
 tb/tb_apx_mult_seq_engine.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apx_mult_seq_engine.sv
// Purpose: shift-add engine returning exact and approximate (NAB-LSB truncated/rounded) products.
// Latency: out_valid rises WIDTH cycles after the input handshake; one pair in flight at a time.
// Backpressure: results hold in DONE until out_ready; in_ready stays low from acceptance to handshake.
module apx_mult_seq_engine #(
    parameter int WIDTH  = 32,
    parameter int NAB    = 14,
    parameter int BT_RND = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c_acc,
    output logic [WIDTH-1:0] c_apx,
    output logic [WIDTH-1:0] c_err,
    output logic             err_nz,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [WIDTH-1:0] LSB_MASK = (WIDTH'(1) << NAB) - WIDTH'(1);
    localparam logic [WIDTH-1:0] KEEP     = ~LSB_MASK;
    localparam logic [WIDTH-1:0] SAT      = {1'b0, {(WIDTH-1){1'b1}}} & KEEP;
    localparam logic [WIDTH:0]   HALF     = (NAB == 0) ? '0 : ((WIDTH+1)'(1) << ((NAB > 0) ? NAB-1 : 0));

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } pair_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    pair_t           exact_r;
    pair_t           apx_r;
    logic [CW-1:0]   count;

    // Rounding is done one bit wider so a positive overflow is visible and can saturate.
    function automatic logic [WIDTH-1:0] approx(input logic [WIDTH-1:0] x);
        logic [WIDTH:0] s;
        if (NAB == 0)
            return x;
        if (BT_RND == 0)
            return x & KEEP;
        s = {x[WIDTH-1], x} + HALF;
        if (!s[WIDTH] && s[WIDTH-1])
            return SAT;
        return s[WIDTH-1:0] & KEEP;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            exact_r   <= '0;
            apx_r     <= '0;
            count     <= '0;
            c_acc     <= '0;
            c_apx     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        exact_r  <= '{a: a, b: b};
                        apx_r    <= '{a: approx(a), b: approx(b)};
                        count    <= '0;
                        c_acc    <= '0;
                        c_apx    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    // Unsigned partial products over raw bit patterns give the right low WIDTH bits.
                    if (exact_r.b[count])
                        c_acc <= c_acc + (exact_r.a << count);
                    if (apx_r.b[count])
                        c_apx <= c_apx + (apx_r.a << count);
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH-1)) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign c_err  = c_acc - c_apx;
    assign err_nz = (c_acc != c_apx);

endmodule

// File: tb/tb_apx_mult_seq_engine.sv
// Bench for apx_mult_seq_engine: default, NAB=0 and truncating builds run in lockstep on shared stimulus.
module tb_apx_mult_seq_engine;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;

    logic        in_ready0, out_valid0, err_nz0, busy0;
    logic [31:0] c_acc0, c_apx0, c_err0;
    logic        in_ready1, out_valid1, err_nz1, busy1;
    logic [31:0] c_acc1, c_apx1, c_err1;
    logic        in_ready2, out_valid2, err_nz2, busy2;
    logic [31:0] c_acc2, c_apx2, c_err2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    apx_mult_seq_engine #(.WIDTH(32), .NAB(14), .BT_RND(1)) dut_rnd (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .a(a), .b(b),
        .out_valid(out_valid0), .out_ready(out_ready), .c_acc(c_acc0), .c_apx(c_apx0),
        .c_err(c_err0), .err_nz(err_nz0), .busy(busy0));

    apx_mult_seq_engine #(.WIDTH(32), .NAB(0), .BT_RND(1)) dut_nab0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .a(a), .b(b),
        .out_valid(out_valid1), .out_ready(out_ready), .c_acc(c_acc1), .c_apx(c_apx1),
        .c_err(c_err1), .err_nz(err_nz1), .busy(busy1));

    apx_mult_seq_engine #(.WIDTH(32), .NAB(14), .BT_RND(0)) dut_trn (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .a(a), .b(b),
        .out_valid(out_valid2), .out_ready(out_ready), .c_acc(c_acc2), .c_apx(c_apx2),
        .c_err(c_err2), .err_nz(err_nz2), .busy(busy2));

    // Reference: signed integer arithmetic, floor to a multiple of 2^nab, clamp at the positive limit.
    function automatic logic [31:0] mdl_apx(input logic [31:0] x, input int nab, input bit rnd);
        longint v, step, lim;
        v    = longint'($signed(x));
        step = longint'(1) << nab;
        lim  = 64'sd2147483647;
        if (rnd && nab > 0)
            v = v + step / 2;
        v = (v >>> nab) <<< nab;
        if (v > lim)
            v = lim - (lim % step);
        return 32'(v);
    endfunction

    function automatic logic [31:0] mdl_mul(input logic [31:0] x, input logic [31:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return 32'(p);
    endfunction

    // Offers one pair, then returns at the first negedge where out_valid is seen (lat edges after acceptance).
    task automatic send(input logic [31:0] xa, input logic [31:0] xb, output int lat);
        int k;
        k = 0;
        while (!in_ready0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        in_valid = 1'b1;
        a = xa;
        b = xb;
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 0;
        while (!out_valid0 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int seen;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({in_ready0, out_valid0, busy0, err_nz0} !== 4'b1000 || c_acc0 !== 0 || c_apx0 !== 0 || c_err0 !== 0) begin
            n_bad++;
            $display("FAIL reset_state: rdy/vld/busy/nz=%b acc=%h apx=%h err=%h, want 1000 and zeros",
                     {in_ready0, out_valid0, busy0, err_nz0}, c_acc0, c_apx0, c_err0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        a = 32'h1234_5678;
        b = 32'h0FED_CBA9;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (busy0 !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_busy_before: busy=%b, want 1", busy0);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({in_ready0, out_valid0, busy0} !== 3'b100 || c_acc0 !== 0 || c_apx0 !== 0) begin
            n_bad++;
            $display("FAIL reset_mid_busy: rdy/vld/busy=%b acc=%h apx=%h, want 100 and zeros",
                     {in_ready0, out_valid0, busy0}, c_acc0, c_apx0);
        end
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid0) seen++;
        end
        n_cmp++;
        if (seen !== 0 || in_ready0 !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_no_emit: out_valid cycles=%0d in_ready=%b, want 0 and 1", seen, in_ready0);
        end
    endtask

    task automatic test_small();
        int lat;
        send(32'd3, 32'd5, lat);
        n_cmp++;
        if (lat !== 32) begin
            n_bad++;
            $display("FAIL small_latency: got %0d edges, want 32", lat);
        end
        n_cmp++;
        if (c_acc0 !== 32'h0000000F || c_apx0 !== 32'h0 || c_err0 !== 32'h0000000F || err_nz0 !== 1'b1) begin
            n_bad++;
            $display("FAIL small_result: acc=%h apx=%h err=%h nz=%b, want 0000000f 00000000 0000000f 1",
                     c_acc0, c_apx0, c_err0, err_nz0);
        end
        drain();
        n_cmp++;
        if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
            n_bad++;
            $display("FAIL small_handshake: in_ready=%b out_valid=%b, want 1 0", in_ready0, out_valid0);
        end
    endtask

    task automatic test_boundaries();
        int lat;
        send(32'h0000_4000, 32'h0000_2000, lat);
        n_cmp++;
        if (c_acc0 !== 32'h0800_0000 || c_apx0 !== 32'h1000_0000 || c_err0 !== 32'hF800_0000 || lat !== 32) begin
            n_bad++;
            $display("FAIL round_up: acc=%h apx=%h err=%h lat=%0d, want 08000000 10000000 f8000000 32",
                     c_acc0, c_apx0, c_err0, lat);
        end
        drain();
        send(32'hFFFF_FFFF, 32'h0001_0000, lat);
        n_cmp++;
        if (c_acc0 !== 32'hFFFF_0000 || c_apx0 !== 32'h0) begin
            n_bad++;
            $display("FAIL neg_to_zero: acc=%h apx=%h, want ffff0000 00000000", c_acc0, c_apx0);
        end
        drain();
        send(32'h7FFF_FFFF, 32'h0000_4000, lat);
        n_cmp++;
        if (c_acc0 !== 32'hFFFF_C000 || c_apx0 !== 32'hF000_0000) begin
            n_bad++;
            $display("FAIL saturate: acc=%h apx=%h, want ffffc000 f0000000", c_acc0, c_apx0);
        end
        drain();
        // -8192 sits exactly on the tie and must round up to zero.
        send(32'hFFFF_E000, 32'h0000_4000, lat);
        n_cmp++;
        if (c_acc0 !== 32'hF800_0000 || c_apx0 !== 32'h0 || err_nz0 !== 1'b1) begin
            n_bad++;
            $display("FAIL neg_tie: acc=%h apx=%h nz=%b, want f8000000 00000000 1", c_acc0, c_apx0, err_nz0);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] hold_acc, hold_apx, hold_err;
        logic [31:0] na, nb;
        int unstable;
        send(32'hDEAD_BEEF, 32'h0BAD_F00D, lat);
        hold_acc = c_acc0;
        hold_apx = c_apx0;
        hold_err = c_err0;
        n_cmp++;
        if (hold_acc !== mdl_mul(32'hDEAD_BEEF, 32'h0BAD_F00D)) begin
            n_bad++;
            $display("FAIL bp_result: acc=%h, want %h", hold_acc, mdl_mul(32'hDEAD_BEEF, 32'h0BAD_F00D));
        end
        unstable = 0;
        in_valid = 1'b1;
        a = 32'h1111_1111;
        b = 32'h2222_2222;
        repeat (10) begin
            @(negedge clk);
            if (c_acc0 !== hold_acc || c_apx0 !== hold_apx || c_err0 !== hold_err ||
                out_valid0 !== 1'b1 || in_ready0 !== 1'b0)
                unstable++;
        end
        n_cmp++;
        if (unstable !== 0) begin
            n_bad++;
            $display("FAIL bp_stable: %0d unstable cycles, want 0", unstable);
        end
        na = $urandom;
        nb = $urandom;
        a = na;
        b = nb;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", in_ready0, out_valid0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (busy0 !== 1'b1 || in_ready0 !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_accept: busy=%b in_ready=%b, want 1 0", busy0, in_ready0);
        end
        lat = 0;
        while (!out_valid0 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (lat !== 32 || c_acc0 !== mdl_mul(na, nb) ||
            c_apx0 !== mdl_mul(mdl_apx(na, 14, 1), mdl_apx(nb, 14, 1))) begin
            n_bad++;
            $display("FAIL b2b_result: lat=%0d acc=%h apx=%h, want 32 %h %h", lat, c_acc0, c_apx0,
                     mdl_mul(na, nb), mdl_mul(mdl_apx(na, 14, 1), mdl_apx(nb, 14, 1)));
        end
        drain();
    endtask

    task automatic test_random(input int n);
        int lat;
        logic [31:0] ra, rb, e_acc, e_rnd, e_trn;
        logic [31:0] corner [6];
        corner = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_E000, 32'h0000_1FFF, 32'h7FFF_E000, 32'h0};
        for (int i = 0; i < n; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            send(ra, rb, lat);
            e_acc = mdl_mul(ra, rb);
            e_rnd = mdl_mul(mdl_apx(ra, 14, 1), mdl_apx(rb, 14, 1));
            e_trn = mdl_mul(mdl_apx(ra, 14, 0), mdl_apx(rb, 14, 0));
            n_cmp++;
            if (lat !== 32 || c_acc0 !== e_acc || c_apx0 !== e_rnd || c_err0 !== e_acc - e_rnd ||
                err_nz0 !== (e_acc != e_rnd)) begin
                n_bad++;
                $display("FAIL rnd_pair a=%h b=%h: lat=%0d acc=%h apx=%h err=%h nz=%b, want 32 %h %h %h %b",
                         ra, rb, lat, c_acc0, c_apx0, c_err0, err_nz0, e_acc, e_rnd, e_acc - e_rnd, e_acc != e_rnd);
            end
            n_cmp++;
            if (out_valid1 !== 1'b1 || c_acc1 !== e_acc || c_apx1 !== e_acc || err_nz1 !== 1'b0 || c_err1 !== 0) begin
                n_bad++;
                $display("FAIL nab0_pair a=%h b=%h: vld=%b acc=%h apx=%h nz=%b, want 1 %h %h 0",
                         ra, rb, out_valid1, c_acc1, c_apx1, err_nz1, e_acc, e_acc);
            end
            n_cmp++;
            if (out_valid2 !== 1'b1 || c_acc2 !== e_acc || c_apx2 !== e_trn || c_err2 !== e_acc - e_trn) begin
                n_bad++;
                $display("FAIL trunc_pair a=%h b=%h: vld=%b acc=%h apx=%h err=%h, want 1 %h %h %h",
                         ra, rb, out_valid2, c_acc2, c_apx2, c_err2, e_acc, e_trn, e_acc - e_trn);
            end
            drain();
        end
    endtask

    initial begin
        test_reset();
        test_small();
        test_boundaries();
        test_back_to_back();
        test_random(600);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
